// File: rtl/button_event_arbiter_pkg.sv
// button_event_arbiter_pkg: shared types, constants and helpers for the button event arbiter.
package button_event_arbiter_pkg;

    localparam int CLK_PERIOD_NS = 8;

    typedef enum logic {SLOT_EMPTY, SLOT_FULL} slot_state_e;

    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + 5'(v[i]);
        return c;
    endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: round-robin pick of the first request at or above ptr, wrapping.
module rr_priority_picker #(
    parameter int WIDTH = 4,
    parameter int ID_W  = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [WIDTH-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id
);

    logic [2*WIDTH-1:0] dbl;
    logic [WIDTH-1:0]   rot;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum;
    logic               hit;

    always_comb begin
        dbl = {req, req} >> ptr;
        rot = dbl[WIDTH-1:0];
        off = '0;
        hit = 1'b0;
        // descending scan so the lowest rotated index wins
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                off = ID_W'(i);
                hit = 1'b1;
            end
        end
        sum    = {1'b0, off} + {1'b0, ptr};
        gnt_id = (sum >= (ID_W+1)'(WIDTH)) ? ID_W'(sum - (ID_W+1)'(WIDTH)) : sum[ID_W-1:0];
        gnt    = hit ? (WIDTH'(1) << gnt_id) : '0;
    end

endmodule

// File: rtl/button_event_arbiter.sv
// button_event_arbiter: serializes per-channel edge pulses into one valid/ready event stream
// with round-robin service and a saturating drop counter.
module button_event_arbiter
    import button_event_arbiter_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int CNT_W = 8,
    localparam int ID_W  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] edge_pulse,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] pending,
    output logic [CNT_W-1:0] drop_count,
    input  logic             drop_clear
);

    slot_state_e      state_q, state_d;
    logic [WIDTH-1:0] pending_q, pending_d, pick_gnt, gnt, drops;
    logic [ID_W-1:0]  pick_id, evt_id_q, evt_id_d, rr_q, rr_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [CNT_W+4:0] drop_sum;
    logic             xfer, grant_en;

    rr_priority_picker #(.WIDTH(WIDTH), .ID_W(ID_W)) u_picker (
        .req    (pending_q),
        .ptr    (rr_q),
        .gnt    (pick_gnt),
        .gnt_id (pick_id)
    );

    always_comb begin
        xfer      = (state_q == SLOT_FULL) && evt_ready;
        grant_en  = ((state_q == SLOT_EMPTY) || xfer) && (|pending_q);
        gnt       = grant_en ? pick_gnt : '0;
        pending_d = (pending_q & ~gnt) | edge_pulse;
        drops     = edge_pulse & pending_q & ~gnt;
        state_d   = grant_en ? SLOT_FULL : (xfer ? SLOT_EMPTY : state_q);
        evt_id_d  = grant_en ? pick_id : evt_id_q;
        rr_d      = grant_en ? ((pick_id == ID_W'(WIDTH - 1)) ? '0 : pick_id + 1'b1) : rr_q;
        // clear applies to the old count only; same-cycle drops still land
        drop_sum  = (drop_clear ? '0 : (CNT_W+5)'(drop_q)) + (CNT_W+5)'(popcount16(16'(drops)));
        drop_d    = (drop_sum > (CNT_W+5)'({CNT_W{1'b1}})) ? '1 : drop_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= SLOT_EMPTY;
            pending_q <= '0;
            evt_id_q  <= '0;
            rr_q      <= '0;
            drop_q    <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            evt_id_q  <= evt_id_d;
            rr_q      <= rr_d;
            drop_q    <= drop_d;
        end
    end

    assign evt_valid  = (state_q == SLOT_FULL);
    assign evt_id     = evt_id_q;
    assign pending    = pending_q;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// tb_button_event_arbiter: directed and randomized checks against a behavioural model.
module tb_button_event_arbiter;

    localparam int W  = 4;
    localparam int CW = 8;
    localparam int IW = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  edge_pulse = '0;
    logic          evt_ready = 1'b0;
    logic          drop_clear = 1'b0;
    logic          evt_valid;
    logic [IW-1:0] evt_id;
    logic [W-1:0]  pending;
    logic [CW-1:0] drop_count;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] m_pend;
    bit           m_valid;
    int           m_id, m_rr, m_drop;
    int           dut_q[$];

    button_event_arbiter #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .edge_pulse (edge_pulse),
        .evt_valid  (evt_valid),
        .evt_id     (evt_id),
        .evt_ready  (evt_ready),
        .pending    (pending),
        .drop_count (drop_count),
        .drop_clear (drop_clear)
    );

    always #4 clk = ~clk;

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 0;
        m_id    = 0;
        m_rr    = 0;
        m_drop  = 0;
        dut_q.delete();
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        model_reset();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // one clock: apply inputs, capture any transfer, advance the model
    task automatic step(input logic [W-1:0] p, input logic r, input logic clr);
        int w, cnt, c;
        bit xf;
        edge_pulse = p;
        evt_ready  = r;
        drop_clear = clr;
        #1;
        if (evt_valid && evt_ready) dut_q.push_back(int'(evt_id));
        @(posedge clk);
        xf = m_valid && r;
        w  = -1;
        if (!m_valid || xf)
            for (int j = 0; j < W; j++) begin
                c = (m_rr + j) % W;
                if (w < 0 && m_pend[c]) w = c;
            end
        cnt = 0;
        for (int i = 0; i < W; i++) if (p[i] && m_pend[i] && i != w) cnt++;
        m_drop = (clr ? 0 : m_drop) + cnt;
        if (m_drop > 255) m_drop = 255;
        for (int i = 0; i < W; i++) m_pend[i] = (m_pend[i] && i != w) || p[i];
        if (w >= 0) begin
            m_id    = w;
            m_valid = 1;
            m_rr    = (w + 1) % W;
        end else if (xf) m_valid = 0;
        #1;
        edge_pulse = '0;
        drop_clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        checks++;
        if (evt_valid !== 1'b0 || evt_id !== '0 || pending !== '0 || drop_count !== '0) begin
            errors++;
            $display("FAIL reset_state: valid=%b id=%0d pending=%b drops=%0d, required all 0",
                     evt_valid, evt_id, pending, drop_count);
        end
        do_reset();
    endtask

    task automatic test_single();
        do_reset();
        step(4'b0100, 1, 0);
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b0100) begin
            errors++;
            $display("FAIL single_k: valid=%b pending=%b, required 0 / 0100", evt_valid, pending);
        end
        step('0, 1, 0);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd2 || pending !== '0) begin
            errors++;
            $display("FAIL single_k1: valid=%b id=%0d pending=%b, required 1 / 2 / 0000",
                     evt_valid, evt_id, pending);
        end
        step('0, 1, 0);
        checks++;
        if (evt_valid !== 1'b0 || drop_count !== '0 || dut_q.size() != 1) begin
            errors++;
            $display("FAIL single_after: valid=%b drops=%0d delivered=%0d, required 0 / 0 / 1",
                     evt_valid, drop_count, dut_q.size());
        end
    endtask

    task automatic test_all_channels();
        do_reset();
        step(4'b1111, 1, 0);
        for (int i = 0; i < W; i++) begin
            step('0, 1, 0);
            checks++;
            if (evt_valid !== 1'b1 || evt_id !== IW'(i)) begin
                errors++;
                $display("FAIL rr_all[%0d]: valid=%b id=%0d, required 1 / %0d", i, evt_valid, evt_id, i);
            end
        end
        step(4'b1001, 1, 0);
        checks++;
        if (evt_valid !== 1'b0 || pending !== 4'b1001) begin
            errors++;
            $display("FAIL rr_gap: valid=%b pending=%b, required 0 / 1001", evt_valid, pending);
        end
        step('0, 1, 0);
        checks++;
        if (evt_id !== 2'd0 || evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_pair0: id=%0d valid=%b, required 0 / 1", evt_id, evt_valid);
        end
        step('0, 1, 0);
        checks++;
        if (evt_id !== 2'd3 || evt_valid !== 1'b1) begin
            errors++;
            $display("FAIL rr_pair1: id=%0d valid=%b, required 3 / 1", evt_id, evt_valid);
        end
    endtask

    task automatic test_hold_drop();
        int ones;
        do_reset();
        step(4'b0001, 0, 0);
        step('0, 0, 0);
        step(4'b0010, 0, 0);
        step(4'b0010, 0, 0);
        checks++;
        if (drop_count !== 8'd1 || pending !== 4'b0010) begin
            errors++;
            $display("FAIL hold_drop: drops=%0d pending=%b, required 1 / 0010", drop_count, pending);
        end
        for (int i = 0; i < 5; i++) begin
            step('0, 0, 0);
            checks++;
            if (evt_valid !== 1'b1 || evt_id !== 2'd0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: valid=%b id=%0d, required 1 / 0", i, evt_valid, evt_id);
            end
        end
        for (int i = 0; i < 3; i++) step('0, 1, 0);
        ones = 0;
        foreach (dut_q[i]) if (dut_q[i] == 1) ones++;
        checks++;
        if (ones != 1 || dut_q.size() != 2 || evt_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: ch1 events=%0d total=%0d valid=%b, required 1 / 2 / 0",
                     ones, dut_q.size(), evt_valid);
        end
    endtask

    task automatic test_slot_pulse();
        do_reset();
        step(4'b0100, 0, 0);
        step('0, 0, 0);
        step(4'b0100, 0, 0);
        checks++;
        if (drop_count !== '0 || pending !== 4'b0100 || evt_id !== 2'd2) begin
            errors++;
            $display("FAIL slot_pulse: drops=%0d pending=%b id=%0d, required 0 / 0100 / 2",
                     drop_count, pending, evt_id);
        end
        step('0, 1, 0);
        step('0, 1, 0);
        step('0, 1, 0);
        checks++;
        if (dut_q.size() != 2 || dut_q[0] != 2 || dut_q[dut_q.size()-1] != 2) begin
            errors++;
            $display("FAIL slot_twice: delivered=%0d events, required two id 2 events", dut_q.size());
        end
    endtask

    task automatic test_saturate();
        do_reset();
        step(4'b1111, 0, 0);
        step('0, 0, 0);
        for (int i = 0; i < 87; i++) step(4'b1110, 0, 0);
        checks++;
        if (drop_count !== 8'd255) begin
            errors++;
            $display("FAIL sat: drops=%0d, required 255", drop_count);
        end
        step(4'b0010, 0, 1);
        checks++;
        if (drop_count !== 8'd1) begin
            errors++;
            $display("FAIL clear_plus_drop: drops=%0d, required 1", drop_count);
        end
        step('0, 0, 1);
        checks++;
        if (drop_count !== 8'd0) begin
            errors++;
            $display("FAIL clear: drops=%0d, required 0", drop_count);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(4'b1111, 0, 0);
        step('0, 0, 0);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if (evt_valid !== 1'b0 || evt_id !== '0 || pending !== '0 || drop_count !== '0) begin
            errors++;
            $display("FAIL reset_mid: valid=%b id=%0d pending=%b drops=%0d, required all 0",
                     evt_valid, evt_id, pending, drop_count);
        end
        #1 rst_n = 1'b1;
        step(4'b1000, 1, 0);
        step('0, 1, 0);
        checks++;
        if (evt_valid !== 1'b1 || evt_id !== 2'd3) begin
            errors++;
            $display("FAIL reset_resume: valid=%b id=%0d, required 1 / 3", evt_valid, evt_id);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] p;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            p = W'($urandom_range(0, 15)) & W'($urandom_range(0, 15));
            step(p, $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0);
            checks++;
            if (evt_valid !== m_valid || evt_id !== IW'(m_id) || pending !== m_pend ||
                drop_count !== CW'(m_drop)) begin
                errors++;
                $display("FAIL random[%0d]: valid=%b id=%0d pending=%b drops=%0d, required %b / %0d / %b / %0d",
                         n, evt_valid, evt_id, pending, drop_count, m_valid, m_id, m_pend, m_drop);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_all_channels();
        test_hold_drop();
        test_slot_pulse();
        test_saturate();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
